// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: per-channel edge detection with round-robin delivery over one valid/ready port
module edge_event_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] a_i,
    output logic              event_valid_o,
    input  logic              event_ready_i,
    output logic [CH_W-1:0]   event_ch_o,
    output logic              event_rise_o,
    output logic [NUM_CH-1:0] ovf_o,
    input  logic [NUM_CH-1:0] ovf_clr_i
);
    logic [NUM_CH-1:0] r_a_q;
    logic [NUM_CH-1:0] r_rise_pend;
    logic [NUM_CH-1:0] r_fall_pend;
    logic [NUM_CH-1:0] r_ovf;
    logic              r_valid;
    logic [CH_W-1:0]   r_ch;
    logic              r_rise;
    logic [CH_W-1:0]   r_rr_ptr;
    logic [NUM_CH-1:0] w_rise_det;
    logic [NUM_CH-1:0] w_fall_det;
    logic [NUM_CH-1:0] w_req;
    logic              w_free;
    logic              w_load;
    logic [CH_W-1:0]   w_gnt_ch;
    logic              w_gnt_hit;
    logic              w_gnt_rise;
    logic [NUM_CH-1:0] w_gnt_oh;
    logic [NUM_CH-1:0] w_rise_keep;
    logic [NUM_CH-1:0] w_fall_keep;
    logic [NUM_CH-1:0] w_ovf_set;
    logic [CH_W-1:0]   w_next_ptr;

    assign w_rise_det  = a_i & ~r_a_q;
    assign w_fall_det  = ~a_i & r_a_q;
    assign w_req       = r_rise_pend | r_fall_pend;
    assign w_free      = ~r_valid | event_ready_i;
    assign w_load      = w_free & w_gnt_hit;
    assign w_gnt_rise  = r_rise_pend[w_gnt_ch];
    assign w_gnt_oh    = {{(NUM_CH-1){1'b0}}, 1'b1} << w_gnt_ch;
    assign w_rise_keep = r_rise_pend & ~((w_load & w_gnt_rise) ? w_gnt_oh : '0);
    assign w_fall_keep = r_fall_pend & ~((w_load & ~w_gnt_rise) ? w_gnt_oh : '0);
    assign w_ovf_set   = (w_rise_det & w_rise_keep) | (w_fall_det & w_fall_keep);
    assign w_next_ptr  = (w_gnt_ch == CH_W'(NUM_CH-1)) ? '0 : w_gnt_ch + CH_W'(1);

    assign event_valid_o = r_valid;
    assign event_ch_o    = r_ch;
    assign event_rise_o  = r_rise;
    assign ovf_o         = r_ovf;

    // First requesting channel at or after the round-robin pointer, wrapping around
    always_comb begin
        w_gnt_ch  = '0;
        w_gnt_hit = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!w_gnt_hit && w_req[(int'(r_rr_ptr) + i) % NUM_CH]) begin
                w_gnt_ch  = CH_W'((int'(r_rr_ptr) + i) % NUM_CH);
                w_gnt_hit = 1'b1;
            end
        end
    end

    // Edge history, pending flags and sticky overflow; a new edge re-arms a flag cleared by the same load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a_q       <= '0;
            r_rise_pend <= '0;
            r_fall_pend <= '0;
            r_ovf       <= '0;
        end else begin
            r_a_q       <= a_i;
            r_rise_pend <= w_rise_keep | w_rise_det;
            r_fall_pend <= w_fall_keep | w_fall_det;
            r_ovf       <= (r_ovf & ~ovf_clr_i) | w_ovf_set;
        end
    end

    // Output event register and round-robin pointer; holds while stalled by the consumer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid  <= 1'b0;
            r_ch     <= '0;
            r_rise   <= 1'b0;
            r_rr_ptr <= '0;
        end else if (w_load) begin
            r_valid  <= 1'b1;
            r_ch     <= w_gnt_ch;
            r_rise   <= w_gnt_rise;
            r_rr_ptr <= w_next_ptr;
        end else if (w_free) begin
            r_valid  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter: directed stimulus checked against a behavioural event-scheduler model
module tb_edge_event_arbiter;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] a_i = '0;
    logic         event_valid_o;
    logic         event_ready_i = 1'b0;
    logic [1:0]   event_ch_o;
    logic         event_rise_o;
    logic [N-1:0] ovf_o;
    logic [N-1:0] ovf_clr_i = '0;

    int total = 0;
    int bad = 0;

    bit       m_rp[N];
    bit       m_fp[N];
    bit       m_aq[N];
    bit [N-1:0] m_ovf;
    bit       m_valid;
    bit       m_rise;
    int       m_ch;
    int       m_rr;

    edge_event_arbiter #(.NUM_CH(N)) dut (
        .clk(clk),
        .reset(reset),
        .a_i(a_i),
        .event_valid_o(event_valid_o),
        .event_ready_i(event_ready_i),
        .event_ch_o(event_ch_o),
        .event_rise_o(event_rise_o),
        .ovf_o(ovf_o),
        .ovf_clr_i(ovf_clr_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Literal expectation applied to both the DUT and the model
    task automatic lit(input string nm, input int v, input int ch, input int r);
        chk({nm, " valid"}, event_valid_o, v);
        chk({nm, " model valid"}, m_valid, v);
        if (v != 0) begin
            chk({nm, " ch"}, event_ch_o, ch);
            chk({nm, " rise"}, event_rise_o, r);
            chk({nm, " model ch"}, m_ch, ch);
            chk({nm, " model rise"}, m_rise, r);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_rp[c] = 0;
            m_fp[c] = 0;
            m_aq[c] = 0;
        end
        m_ovf = '0;
        m_valid = 0;
        m_rise = 0;
        m_ch = 0;
        m_rr = 0;
    endtask

    // One clock of the scheduler: pick a winner from the old state, then apply all channel updates
    task automatic model_step();
        bit free;
        bit ld;
        bit sr;
        int g;
        bit rise;
        bit fall;
        bit rp_after;
        bit fp_after;
        free = !m_valid || event_ready_i;
        g = -1;
        for (int i = 0; i < N; i++) begin
            if (g < 0 && (m_rp[(m_rr + i) % N] || m_fp[(m_rr + i) % N])) g = (m_rr + i) % N;
        end
        ld = free && g >= 0;
        sr = 0;
        if (ld) sr = m_rp[g];
        for (int c = 0; c < N; c++) begin
            rise = a_i[c] && !m_aq[c];
            fall = !a_i[c] && m_aq[c];
            rp_after = m_rp[c] && !(ld && c == g && sr);
            fp_after = m_fp[c] && !(ld && c == g && !sr);
            if (ovf_clr_i[c]) m_ovf[c] = 0;
            if ((rise && rp_after) || (fall && fp_after)) m_ovf[c] = 1;
            m_rp[c] = rp_after || rise;
            m_fp[c] = fp_after || fall;
            m_aq[c] = a_i[c];
        end
        if (ld) begin
            m_valid = 1;
            m_ch = g;
            m_rise = sr;
            m_rr = (g + 1) % N;
        end else if (free) begin
            m_valid = 0;
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) model_reset();
        else model_step();
    end

    // Cycle-by-cycle comparison against the model
    always @(posedge clk) begin
        #1;
        if (reset) begin
            chk("cyc valid", event_valid_o, m_valid);
            chk("cyc ch", event_ch_o, m_ch);
            chk("cyc rise", event_rise_o, m_rise);
            chk("cyc ovf", ovf_o, m_ovf);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        repeat (2) step();
        chk("reset valid", event_valid_o, 0);
        chk("reset ch", event_ch_o, 0);
        chk("reset rise", event_rise_o, 0);
        chk("reset ovf", ovf_o, 0);
        reset = 1'b1;

        event_ready_i = 1'b1;
        a_i = 4'b0100;
        step(); lit("t1 latency", 0, 0, 0);
        step(); lit("t1 rise", 1, 2, 1);
        step(); lit("t1 empty", 0, 0, 0);
        a_i = 4'b0000;
        step(); step(); lit("t1 fall", 1, 2, 0);
        step(); lit("t1 empty2", 0, 0, 0);

        reset = 1'b0;
        step();
        reset = 1'b1;
        a_i = 4'b1111;
        step();
        for (int i = 0; i < N; i++) begin
            step(); lit("t2 rise", 1, i, 1);
        end
        a_i = 4'b0000;
        step(); lit("t2 gap", 0, 0, 0);
        for (int i = 0; i < N; i++) begin
            step(); lit("t2 fall", 1, i, 0);
        end
        step(); lit("t2 empty", 0, 0, 0);

        event_ready_i = 1'b0;
        a_i = 4'b0010;
        step(); step(); lit("t3 present", 1, 1, 1);
        for (int i = 0; i < 10; i++) begin
            step(); lit("t3 hold", 1, 1, 1);
        end
        event_ready_i = 1'b1;
        step(); lit("t3 consumed", 0, 0, 0);
        a_i = 4'b0000;
        step(); step(); lit("t3 fall", 1, 1, 0);
        step(); lit("t3 empty", 0, 0, 0);

        event_ready_i = 1'b0;
        a_i = 4'b0001;
        step(); step(); lit("t4 hold", 1, 0, 1);
        a_i = 4'b1001; step();
        a_i = 4'b0001; step();
        a_i = 4'b1001; step();
        chk("t4 ovf set", ovf_o, 4'b1000);
        lit("t4 still", 1, 0, 1);
        ovf_clr_i = 4'b1000; step(); ovf_clr_i = 4'b0000;
        chk("t4 ovf clr", ovf_o, 4'b0000);
        a_i = 4'b0001; ovf_clr_i = 4'b1000; step(); ovf_clr_i = 4'b0000;
        chk("t4 set wins", ovf_o, 4'b1000);
        event_ready_i = 1'b1;
        ovf_clr_i = 4'b1000; step(); ovf_clr_i = 4'b0000;
        lit("t4 drain rise", 1, 3, 1);
        chk("t4 ovf clr2", ovf_o, 4'b0000);
        step(); lit("t4 drain fall", 1, 3, 0);
        step(); lit("t4 empty", 0, 0, 0);

        a_i = 4'b0000;
        step(); step(); lit("t5 pre fall", 1, 0, 0);
        step(); lit("t5 pre empty", 0, 0, 0);
        event_ready_i = 1'b0;
        a_i = 4'b0010;
        step(); step(); lit("t5 block", 1, 1, 1);
        a_i = 4'b0011; step();
        a_i = 4'b0010; step();
        a_i = 4'b0011; event_ready_i = 1'b1; step();
        lit("t5 collide", 1, 0, 1);
        chk("t5 no ovf", ovf_o, 4'b0000);
        step(); lit("t5 second rise", 1, 0, 1);
        step(); lit("t5 fall", 1, 0, 0);
        step(); lit("t5 empty", 0, 0, 0);

        event_ready_i = 1'b0;
        a_i = 4'b0111;
        step(); step(); lit("t6 present", 1, 2, 1);
        #2 reset = 1'b0;
        #1;
        chk("t6 async valid", event_valid_o, 0);
        chk("t6 async ch", event_ch_o, 0);
        chk("t6 async rise", event_rise_o, 0);
        chk("t6 async ovf", ovf_o, 0);
        step();
        reset = 1'b1;
        event_ready_i = 1'b1;
        step(); step(); lit("t6 rearm 0", 1, 0, 1);
        step(); lit("t6 rearm 1", 1, 1, 1);
        step(); lit("t6 rearm 2", 1, 2, 1);
        step(); lit("t6 empty", 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
- Multi-channel edge-event scheduler. Detects rising and falling edges on NUM_CH single-bit inputs and queues one pending event per edge type per channel.
- Shares a single valid/ready event output port among the channels using round-robin arbitration.
- Sits between raw status lines and a downstream event consumer. A sticky per-channel overflow flags events lost while one is already pending.

Parameters:
- NUM_CH, 4, number of monitored input channels (2..16)
- CH_W, $clog2(NUM_CH), width of channel index

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- a_i  input  NUM_CH  monitored lines; synchronous to clk
- event_valid_o  output  1  output event register holds a valid event
- event_ready_i  input  1  consumer accepts event when high together with event_valid_o
- event_ch_o  output  CH_W  channel index of presented event
- event_rise_o  output  1  1 = rising-edge event, 0 = falling-edge event
- ovf_o  output  NUM_CH  sticky per-channel overflow flags
- ovf_clr_i  input  NUM_CH  per-channel overflow clear; single-cycle strobes

Behaviour:
- Reset (reset=0, asynchronous):
  - a_q, rise_pend, fall_pend, ovf_o, event_valid_o, event_ch_o, event_rise_o, rr_ptr all clear to 0.
  - rr_ptr points at channel 0 as next highest priority.
- Edge detect, per channel c, each clk edge:
  - a_q[c] <= a_i[c].
  - rise_det = a_i & ~a_q; fall_det = ~a_i & a_q.
  - A line high at the first edge after reset release yields a rising event.
- Pending flags:
  - Set on the detecting edge. An edge seen at clk edge k is eligible for grant at edge k+1.
  - Minimum latency a_i change -> event_valid_o = 2 clk edges.
  - Cleared when that flag is loaded into the output register.
- Slot free:
  - free = ~event_valid_o | event_ready_i.
  - When free and any pending, the output register loads the granted event in the same edge.
  - Otherwise the output register holds; event_valid_o, event_ch_o and event_rise_o are stable while valid & ~ready.
  - If free and nothing pending, event_valid_o <= 0.
- Arbitration:
  - Channel request = rise_pend | fall_pend.
  - Grant goes to the first requesting channel searching from rr_ptr upward, with wrap-around modulo NUM_CH.
  - On a load, rr_ptr <= granted channel + 1, wrapping to 0 after NUM_CH-1.
  - Within the granted channel, rise is served before fall; the other flag stays pending.
  - Back-to-back: with event_ready_i held high, one event is accepted per cycle.
- Simultaneous set/clear: if a pending flag is cleared by a load in the same edge a new edge of the same type is detected, the flag stays set. This is not overflow.
- Overflow:
  - An edge detected while its pending flag is already set and not being cleared that edge sets ovf_o[c]. The new event is dropped.
  - ovf_clr_i[c] clears ovf_o[c]; if a set occurs in the same edge, set wins.
- Mid-operation reset: all state clears immediately and asynchronously; the presented event is lost. After release, a_q=0 re-arms rising detection.

Test Plan:
- Single event: reset, event_ready_i=1, drive a_i[2] 0->1 before edge k.
  - rise_pend[2] set at k.
  - event_valid_o=1, event_ch_o=2, event_rise_o=1 after edge k+1.
  - event_valid_o=0 after k+2.
  - Then a_i[2] 1->0 -> one event with event_ch_o=2, event_rise_o=0.
- Round-robin fairness: a_i=4'b1111 in one cycle, event_ready_i=1.
  - Events on channels 0,1,2,3 in consecutive cycles.
  - Then a_i=4'b0000 with rr_ptr=0 -> falling events 0,1,2,3.
- Backpressure: event_ready_i=0, then toggle a_i[1] rise.
  - event_valid_o=1 with event_ch_o=1 holds stable for 10 cycles.
  - Raising event_ready_i consumes it; event_valid_o=0 next cycle.
- Overflow: event_ready_i=0, channel 0 holding a presented event.
  - a_i[3] 0->1 sets rise_pend[3]; a_i[3] 1->0 sets fall_pend[3].
  - a_i[3] 0->1 again sets ovf_o[3]=1.
  - ovf_clr_i[3] pulse -> ovf_o[3]=0.
  - Pulse ovf_clr_i[3] in the same cycle as a further overflow -> ovf_o[3] stays 1.
- Set/clear collision: ready=1, channel 0 rise pending and granted while a_i[0] toggles 1->0->1 so a new rise coincides with the load edge.
  - rise_pend[0] stays 1, ovf_o[0]=0.
  - Second rising event delivered later.
- Async reset: drop reset mid-stream while event_valid_o=1 and between clock edges.
  - All outputs 0 immediately.
  - After release with a_i[0]=1 -> rising event on channel 0.
